// File: rtl/result_drain.sv
// Drains an M x K systolic-array result matrix row-major onto an AXI-Stream
// master, BW 32-bit words per beat, then pulses acc_clear/drain_done once.
module result_drain #(
    parameter int M  = 2,
    parameter int K  = 2,
    parameter int BW = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           done_dispatch,
    input  logic                           array_idle,
    input  logic [0:M-1][0:K-1][31:0]      pe_result,
    output logic [BW*32-1:0]               m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           m_tlast,
    output logic                           acc_clear,
    output logic                           drain_done
);

    localparam int NB = (M * K) / BW;
    localparam int CW = $clog2(NB) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_CLEAR  = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_beat;
    logic [BW*32-1:0]   r_tdata;
    logic               r_tvalid;
    logic               r_tlast;
    logic               r_acc_clear;
    logic               r_drain_done;

    logic [M*K*32-1:0]  w_flat;
    logic [CW-1:0]      w_sel;
    logic [BW*32-1:0]   w_beat_data;
    logic               w_start;
    logic               w_accept;
    logic               w_final;

    // Element e = r*K + c occupies bits [32e +: 32], so beat b is a contiguous slice.
    always_comb begin
        w_flat = '0;
        for (int unsigned r = 0; r < M; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                w_flat[(r*K + c)*32 +: 32] = pe_result[r][c];
            end
        end
    end

    // Beat to load next: beat 0 from IDLE, otherwise the one after the current.
    assign w_sel = (r_state == S_STREAM) ? r_beat + 1'b1 : '0;

    always_comb begin
        w_beat_data = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (w_sel == CW'(b)) begin
                w_beat_data = w_flat[b*BW*32 +: BW*32];
            end
        end
    end

    assign w_start  = done_dispatch & array_idle;
    assign w_accept = r_tvalid & m_tready;
    assign w_final  = (r_beat == CW'(NB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_acc_clear  <= 1'b0;
            r_drain_done <= 1'b0;
        end else begin
            r_acc_clear  <= 1'b0;
            r_drain_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_STREAM;
                        r_beat   <= '0;
                        r_tvalid <= 1'b1;
                        r_tdata  <= w_beat_data;
                        r_tlast  <= (NB == 1);
                    end
                end
                S_STREAM: begin
                    if (w_accept) begin
                        if (w_final) begin
                            r_state      <= S_CLEAR;
                            r_tvalid     <= 1'b0;
                            r_tlast      <= 1'b0;
                            r_acc_clear  <= 1'b1;
                            r_drain_done <= 1'b1;
                        end else begin
                            r_beat  <= w_sel;
                            r_tdata <= w_beat_data;
                            r_tlast <= (w_sel == CW'(NB - 1));
                        end
                    end
                end
                S_CLEAR: begin
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!done_dispatch) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_tdata    = r_tdata;
    assign m_tvalid   = r_tvalid;
    assign m_tlast    = r_tlast;
    assign acc_clear  = r_acc_clear;
    assign drain_done = r_drain_done;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: a 2x2x2 instance driven by directed and
// random scenarios, plus a 4x4x4 instance for the wide row-major case.
module tb_result_drain;

    localparam int M  = 2;
    localparam int K  = 2;
    localparam int BW = 2;
    localparam int NB = (M * K) / BW;

    localparam int M4  = 4;
    localparam int K4  = 4;
    localparam int BW4 = 4;
    localparam int NB4 = (M4 * K4) / BW4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst;
    logic                        done_dispatch;
    logic                        array_idle;
    logic [0:M-1][0:K-1][31:0]   pe_result;
    logic [BW*32-1:0]            m_tdata;
    logic                        m_tvalid;
    logic                        m_tready;
    logic                        m_tlast;
    logic                        acc_clear;
    logic                        drain_done;

    logic                        done4;
    logic                        idle4;
    logic [0:M4-1][0:K4-1][31:0] pe4;
    logic [BW4*32-1:0]           tdata4;
    logic                        tvalid4;
    logic                        tready4;
    logic                        tlast4;
    logic                        clear4;
    logic                        ddone4;

    result_drain #(.M(M), .K(K), .BW(BW)) dut (
        .clk(clk), .rst(rst), .done_dispatch(done_dispatch), .array_idle(array_idle),
        .pe_result(pe_result), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .acc_clear(acc_clear), .drain_done(drain_done)
    );

    result_drain #(.M(M4), .K(K4), .BW(BW4)) dut4 (
        .clk(clk), .rst(rst), .done_dispatch(done4), .array_idle(idle4),
        .pe_result(pe4), .m_tdata(tdata4), .m_tvalid(tvalid4), .m_tready(tready4),
        .m_tlast(tlast4), .acc_clear(clear4), .drain_done(ddone4)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mat  [0:M-1][0:K-1];
    logic [31:0] mat4 [0:M4-1][0:K4-1];

    // Capture log filled by collect()
    logic [BW*32-1:0] cap_data[$];
    bit               cap_last[$];
    int valid_cycles, clear_cnt, done_cnt, clear_cyc, done_cyc;
    int acc_cyc_last, first_valid_cyc, hold_viol;

    function automatic logic [BW*32-1:0] exp_beat(input int b);
        logic [BW*32-1:0] v;
        int e;
        v = '0;
        for (int i = 0; i < BW; i++) begin
            e = b * BW + i;
            v[i*32 +: 32] = mat[e / K][e % K];
        end
        return v;
    endfunction

    function automatic logic [BW4*32-1:0] exp_beat4(input int b);
        logic [BW4*32-1:0] v;
        int e;
        v = '0;
        for (int i = 0; i < BW4; i++) begin
            e = b * BW4 + i;
            v[i*32 +: 32] = mat4[e / K4][e % K4];
        end
        return v;
    endfunction

    task automatic load_mat(input bit fixed);
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < K; c++) begin
                mat[r][c] = fixed ? 32'(r * K + c + 1) : $urandom;
                pe_result[r][c] = mat[r][c];
            end
        end
    endtask

    // Records accepted beats and pulse timing; n counts negedges from the call.
    task automatic collect(input int budget, input int ready_pct, input bit drop_idle);
        bit pend;
        logic [BW*32-1:0] pd;
        bit pl;
        cap_data.delete();
        cap_last.delete();
        valid_cycles = 0; clear_cnt = 0; done_cnt = 0; clear_cyc = -1; done_cyc = -1;
        acc_cyc_last = -1; first_valid_cyc = -1; hold_viol = 0;
        pend = 1'b0; pd = '0; pl = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (pend && !(m_tvalid === 1'b1 && m_tdata === pd && m_tlast === pl)) hold_viol++;
            m_tready = ($urandom_range(0, 99) < ready_pct);
            if (drop_idle) array_idle = 1'($urandom_range(0, 1));
            if (acc_clear === 1'b1) begin clear_cnt++; clear_cyc = n; end
            if (drain_done === 1'b1) begin done_cnt++; done_cyc = n; end
            if (m_tvalid === 1'b1) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = n;
            end
            pend = (m_tvalid === 1'b1) && !m_tready;
            pd = m_tdata;
            pl = m_tlast;
            if (m_tvalid === 1'b1 && m_tready) begin
                cap_data.push_back(m_tdata);
                cap_last.push_back(m_tlast);
                acc_cyc_last = n;
            end
            if (done_cnt > 0 && n >= done_cyc + 2) break;
        end
    endtask

    task automatic go_idle();
        done_dispatch = 1'b0;
        array_idle = 1'b0;
        m_tready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        vectors++; if (m_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
        vectors++; if (m_tdata !== '0) begin miscompares++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
        vectors++; if (acc_clear !== 1'b0) begin miscompares++; $display("FAIL reset_acc_clear: got %b want 0", acc_clear); end
        vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL reset_drain_done: got %b want 0", drain_done); end
        vectors++; if (tvalid4 !== 1'b0 || tdata4 !== '0) begin miscompares++; $display("FAIL reset_wide: got v=%b d=%h want 0", tvalid4, tdata4); end
        rst = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL idle_no_start: got %b want 0", m_tvalid); end
        m_tready = 1'b0;
    endtask

    task automatic test_basic();
        load_mat(1'b1);
        done_dispatch = 1'b1; array_idle = 1'b1; m_tready = 1'b1;
        collect(20, 100, 1'b0);
        vectors++; if (cap_data.size() !== 2) begin miscompares++; $display("FAIL basic_beats: got %0d want 2", cap_data.size()); end
        vectors++; if (cap_data[0] !== 64'h00000002_00000001) begin miscompares++; $display("FAIL basic_beat0: got %h want 0000000200000001", cap_data[0]); end
        vectors++; if (cap_last[0] !== 1'b0) begin miscompares++; $display("FAIL basic_last0: got %b want 0", cap_last[0]); end
        vectors++; if (cap_data[1] !== 64'h00000004_00000003) begin miscompares++; $display("FAIL basic_beat1: got %h want 0000000400000003", cap_data[1]); end
        vectors++; if (cap_last[1] !== 1'b1) begin miscompares++; $display("FAIL basic_last1: got %b want 1", cap_last[1]); end
        vectors++; if (first_valid_cyc !== 0) begin miscompares++; $display("FAIL basic_latency: got %0d want 0", first_valid_cyc); end
        vectors++; if (clear_cnt !== 1 || clear_cyc !== acc_cyc_last + 1) begin miscompares++; $display("FAIL basic_acc_clear: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", clear_cnt, clear_cyc, acc_cyc_last + 1); end
        vectors++; if (done_cnt !== 1 || done_cyc !== acc_cyc_last + 1) begin miscompares++; $display("FAIL basic_drain_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, acc_cyc_last + 1); end
        go_idle();
    endtask

    task automatic test_backpressure();
        load_mat(1'b1);
        done_dispatch = 1'b1; array_idle = 1'b1; m_tready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            vectors++; if (m_tvalid !== 1'b1 || m_tdata !== exp_beat(0) || m_tlast !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold%0d: got v=%b d=%h l=%b want v=1 d=%h l=0", n, m_tvalid, m_tdata, m_tlast, exp_beat(0));
            end
            if (n == 3) m_tready = 1'b1;
        end
        @(negedge clk);
        vectors++; if (m_tvalid !== 1'b1 || m_tdata !== exp_beat(1) || m_tlast !== 1'b1) begin
            miscompares++; $display("FAIL bp_beat1: got v=%b d=%h l=%b want v=1 d=%h l=1", m_tvalid, m_tdata, m_tlast, exp_beat(1));
        end
        @(negedge clk);
        vectors++; if (m_tvalid !== 1'b0 || acc_clear !== 1'b1 || drain_done !== 1'b1) begin
            miscompares++; $display("FAIL bp_clear: got v=%b clr=%b dd=%b want v=0 clr=1 dd=1", m_tvalid, acc_clear, drain_done);
        end
        @(negedge clk);
        vectors++; if (acc_clear !== 1'b0 || drain_done !== 1'b0) begin
            miscompares++; $display("FAIL bp_pulse_width: got clr=%b dd=%b want 0 0", acc_clear, drain_done);
        end
        go_idle();
    endtask

    task automatic test_start_gate();
        load_mat(1'b0);
        done_dispatch = 1'b1; array_idle = 1'b0; m_tready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL gate_cycle%0d: got tvalid=%b want 0", n, m_tvalid); end
        end
        array_idle = 1'b1;
        collect(20, 100, 1'b0);
        vectors++; if (first_valid_cyc !== 0) begin miscompares++; $display("FAIL gate_latency: got %0d want 0", first_valid_cyc); end
        vectors++; if (cap_data.size() !== NB || cap_data[0] !== exp_beat(0) || cap_data[1] !== exp_beat(1)) begin
            miscompares++; $display("FAIL gate_data: got n=%0d b0=%h b1=%h want n=%0d b0=%h b1=%h", cap_data.size(), cap_data[0], cap_data[1], NB, exp_beat(0), exp_beat(1));
        end
        go_idle();
    endtask

    task automatic test_hold();
        load_mat(1'b0);
        done_dispatch = 1'b1; array_idle = 1'b1; m_tready = 1'b1;
        collect(20, 100, 1'b0);
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL hold_first_done: got %0d want 1", done_cnt); end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            vectors++; if (m_tvalid !== 1'b0 || acc_clear !== 1'b0 || drain_done !== 1'b0) begin
                miscompares++; $display("FAIL hold_cycle%0d: got v=%b clr=%b dd=%b want 0 0 0", n, m_tvalid, acc_clear, drain_done);
            end
        end
        go_idle();
        load_mat(1'b0);
        done_dispatch = 1'b1; array_idle = 1'b1; m_tready = 1'b1;
        collect(20, 100, 1'b0);
        vectors++; if (cap_data.size() !== NB || cap_data[0] !== exp_beat(0) || cap_data[1] !== exp_beat(1) || done_cnt !== 1) begin
            miscompares++; $display("FAIL hold_restart: got n=%0d b0=%h b1=%h dd=%0d want n=%0d b0=%h b1=%h dd=1", cap_data.size(), cap_data[0], cap_data[1], done_cnt, NB, exp_beat(0), exp_beat(1));
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        load_mat(1'b0);
        done_dispatch = 1'b1; array_idle = 1'b1; m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (m_tvalid !== 1'b1 || m_tdata !== exp_beat(1)) begin
            miscompares++; $display("FAIL rmid_pre: got v=%b d=%h want v=1 d=%h", m_tvalid, m_tdata, exp_beat(1));
        end
        #2 rst = 1'b1;
        #1;
        vectors++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || acc_clear !== 1'b0 || drain_done !== 1'b0) begin
            miscompares++; $display("FAIL rmid_async: got v=%b l=%b d=%h clr=%b dd=%b want all 0", m_tvalid, m_tlast, m_tdata, acc_clear, drain_done);
        end
        done_dispatch = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            vectors++; if (m_tlast !== 1'b0 || acc_clear !== 1'b0 || drain_done !== 1'b0) begin
                miscompares++; $display("FAIL rmid_quiet%0d: got l=%b clr=%b dd=%b want 0 0 0", n, m_tlast, acc_clear, drain_done);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (m_tvalid !== 1'b0 || acc_clear !== 1'b0 || drain_done !== 1'b0) begin
            miscompares++; $display("FAIL rmid_after: got v=%b clr=%b dd=%b want 0 0 0", m_tvalid, acc_clear, drain_done);
        end
        load_mat(1'b0);
        done_dispatch = 1'b1; array_idle = 1'b1;
        collect(20, 100, 1'b0);
        vectors++; if (cap_data.size() !== NB || cap_data[0] !== exp_beat(0) || cap_last[1] !== 1'b1 || done_cnt !== 1) begin
            miscompares++; $display("FAIL rmid_restart: got n=%0d b0=%h dd=%0d want n=%0d b0=%h dd=1", cap_data.size(), cap_data[0], done_cnt, NB, exp_beat(0));
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        load_mat(1'b0);
        done_dispatch = 1'b1; array_idle = 1'b1; m_tready = 1'b1;
        collect(20, 100, 1'b0);
        vectors++; if (valid_cycles !== NB || first_valid_cyc !== 0 || acc_cyc_last !== NB - 1) begin
            miscompares++; $display("FAIL b2b_timing: got valid=%0d first=%0d last=%0d want %0d 0 %0d", valid_cycles, first_valid_cyc, acc_cyc_last, NB, NB - 1);
        end
        go_idle();
    endtask

    task automatic test_random();
        int errs;
        for (int it = 0; it < 20; it++) begin
            load_mat(1'b0);
            done_dispatch = 1'b1; array_idle = 1'b1;
            m_tready = 1'($urandom_range(0, 1));
            collect(300, $urandom_range(25, 100), 1'b1);
            errs = 0;
            if (cap_data.size() != NB) errs++;
            for (int b = 0; b < NB && b < cap_data.size(); b++) begin
                if (cap_data[b] !== exp_beat(b)) errs++;
                if (cap_last[b] !== (b == NB - 1)) errs++;
            end
            if (hold_viol != 0) errs++;
            if (clear_cnt != 1 || done_cnt != 1 || clear_cyc != acc_cyc_last + 1) errs++;
            vectors++; if (errs !== 0) begin
                miscompares++; $display("FAIL random_it%0d: got %0d errors (beats=%0d holdviol=%0d clr=%0d dd=%0d) want 0", it, errs, cap_data.size(), hold_viol, clear_cnt, done_cnt);
            end
            go_idle();
        end
    endtask

    task automatic test_wide();
        for (int r = 0; r < M4; r++) begin
            for (int c = 0; c < K4; c++) begin
                mat4[r][c] = $urandom;
                pe4[r][c] = mat4[r][c];
            end
        end
        done4 = 1'b1; idle4 = 1'b1; tready4 = 1'b1;
        for (int n = 0; n < NB4; n++) begin
            @(negedge clk);
            vectors++; if (tvalid4 !== 1'b1 || tdata4 !== exp_beat4(n) || tlast4 !== (n == NB4 - 1)) begin
                miscompares++; $display("FAIL wide_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", n, tvalid4, tdata4, tlast4, exp_beat4(n), (n == NB4 - 1));
            end
        end
        @(negedge clk);
        vectors++; if (tvalid4 !== 1'b0 || clear4 !== 1'b1 || ddone4 !== 1'b1) begin
            miscompares++; $display("FAIL wide_clear: got v=%b clr=%b dd=%b want 0 1 1", tvalid4, clear4, ddone4);
        end
        done4 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        done_dispatch = 1'b0; array_idle = 1'b0; m_tready = 1'b0;
        pe_result = '0;
        done4 = 1'b0; idle4 = 1'b0; tready4 = 1'b0;
        pe4 = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_gate();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
